// File: rtl/masked_skinny_subcells_seq_if.sv
// Purpose: share-separated bus between the SubCells sequencer, its host and the external CMS S-box.
// Latency: none (wires only). Backpressure: none; host start is sampled only when the sequencer is idle.
// SUBCELLS_REMASK_EN adds the per-cycle remask byte rnd.
interface masked_skinny_subcells_seq_if #(
    parameter int NBYTES = 16
);
    logic                  start;
    logic [8*NBYTES-1:0]   state_in1;
    logic [8*NBYTES-1:0]   state_in2;
    logic [7:0]            sbox_x1;
    logic [7:0]            sbox_x2;
    logic [7:0]            sbox_y1;
    logic [7:0]            sbox_y2;
    logic [8*NBYTES-1:0]   state_out1;
    logic [8*NBYTES-1:0]   state_out2;
    logic                  busy;
    logic                  done;
`ifdef SUBCELLS_REMASK_EN
    logic [7:0]            rnd;

    modport master (
        output start, state_in1, state_in2, sbox_y1, sbox_y2, rnd,
        input  sbox_x1, sbox_x2, state_out1, state_out2, busy, done
    );
    modport slave (
        input  start, state_in1, state_in2, sbox_y1, sbox_y2, rnd,
        output sbox_x1, sbox_x2, state_out1, state_out2, busy, done
    );
`else
    modport master (
        output start, state_in1, state_in2, sbox_y1, sbox_y2,
        input  sbox_x1, sbox_x2, state_out1, state_out2, busy, done
    );
    modport slave (
        input  start, state_in1, state_in2, sbox_y1, sbox_y2,
        output sbox_x1, sbox_x2, state_out1, state_out2, busy, done
    );
`endif
endinterface

// File: rtl/masked_skinny_subcells_seq.sv
// Purpose: byte-serial SubCells driver for 2-share SKINNY-128 around a pipelined CMS S-box.
// Latency: NBYTES+SBOX_LAT+1 cycles start-to-done. Backpressure: none; start ignored unless IDLE.
// Optional SUBCELLS_REMASK_EN: re-shares every fed byte with the fresh mask rnd.
module masked_skinny_subcells_seq #(
    parameter int NBYTES   = 16,
    parameter int SBOX_LAT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    masked_skinny_subcells_seq_if.slave bus
);
    localparam int              W        = 8 * NBYTES;
    localparam int              CW       = $clog2(NBYTES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(NBYTES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NBYTES - 1);
    localparam logic [CW-1:0]   CNT_LAT  = CW'(SBOX_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]   cap_cnt_q, cap_cnt_d;
    logic [W-1:0]    sh1_q, sh1_d, sh2_q, sh2_d;
    logic [W-1:0]    res1_q, res1_d, res2_q, res2_d;
    logic [W-1:0]    out1_q, out1_d, out2_q, out2_d;
    logic            feed_en;
    logic            cap_en;

    // Capture starts once the first fed byte has crossed the S-box pipeline; feed_cnt saturates at NBYTES.
    assign feed_en = (state_q == RUN) && (feed_cnt_q != CNT_MAX);
    assign cap_en  = (state_q == RUN) && (feed_cnt_q >= CNT_LAT) && (cap_cnt_q != CNT_MAX);

    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh1_d      = bus.state_in1;
                    sh2_d      = bus.state_in2;
                    res1_d     = '0;
                    res2_d     = '0;
                    feed_cnt_d = '0;
                    cap_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (feed_en) begin
                    sh1_d      = {sh1_q[W-9:0], 8'h00};
                    sh2_d      = {sh2_q[W-9:0], 8'h00};
                    feed_cnt_d = feed_cnt_q + CW'(1);
                end
                if (cap_en) begin
                    res1_d    = {res1_q[W-9:0], bus.sbox_y1};
                    res2_d    = {res2_q[W-9:0], bus.sbox_y2};
                    cap_cnt_d = cap_cnt_q + CW'(1);
                    if (cap_cnt_q == CNT_LAST) begin
                        out1_d  = res1_d;
                        out2_d  = res2_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            feed_cnt_q <= '0;
            cap_cnt_q  <= '0;
            sh1_q      <= '0;
            sh2_q      <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
            out1_q     <= '0;
            out2_q     <= '0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
        end
    end

    // Each share is gated on its own; there is no path where share 0 and share 1 meet.
`ifdef SUBCELLS_REMASK_EN
    assign bus.sbox_x1 = {8{feed_en}} & (sh1_q[W-1 -: 8] ^ bus.rnd);
    assign bus.sbox_x2 = {8{feed_en}} & (sh2_q[W-1 -: 8] ^ bus.rnd);
`else
    assign bus.sbox_x1 = {8{feed_en}} & sh1_q[W-1 -: 8];
    assign bus.sbox_x2 = {8{feed_en}} & sh2_q[W-1 -: 8];
`endif

    assign bus.state_out1 = out1_q;
    assign bus.state_out2 = out2_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);

endmodule
